counter_bank: RTL and testbench

//  Bank of CHANNELS independent event counters with per-channel limit, enable and clear.

---
 rtl/counter_bank_if.sv | 35 +++
 rtl/counter_bank.sv | 83 ++++++++
 tb/tb_counter_bank.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_bank_if.sv
// Counter bank bus: event/limit/control inputs and
// live counter, flag and snapshot outputs.
interface counter_bank_if #(
  parameter int CHANNELS   = 4,
  parameter int RESOLUTION = 32
);
  logic                           mode_wrap;
  logic [CHANNELS-1:0]            enable;
  logic [CHANNELS-1:0]            clear;
  logic [CHANNELS*RESOLUTION-1:0] counter_max;
  logic                           capture;
  logic [CHANNELS*RESOLUTION-1:0] counter_out;
  logic [CHANNELS-1:0]            overflow;
  logic [CHANNELS-1:0]            wrapped;
  logic [CHANNELS-1:0]            overflow_sticky;
  logic [CHANNELS*RESOLUTION-1:0] snapshot;
  logic [CHANNELS-1:0]            snapshot_ovf;
  logic                           snapshot_valid;

  modport master (
    output mode_wrap, enable, clear,
    output counter_max, capture,
    input  counter_out, overflow, wrapped,
    input  overflow_sticky, snapshot,
    input  snapshot_ovf, snapshot_valid
  );

  modport slave (
    input  mode_wrap, enable, clear,
    input  counter_max, capture,
    output counter_out, overflow, wrapped,
    output overflow_sticky, snapshot,
    output snapshot_ovf, snapshot_valid
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of independent event counters with limits,
// saturate/wrap mode, sticky overflow and snapshot.
module counter_bank #(
  parameter int CHANNELS         = 4,
  parameter int RESOLUTION       = 32,
  parameter bit CLEAR_ON_CAPTURE = 1'b0
) (
  input logic           clk,
  input logic           reset,
  counter_bank_if.slave bus
);

  typedef logic [CHANNELS-1:0][RESOLUTION-1:0] vec_t;

  localparam logic [RESOLUTION-1:0] ONE =
    RESOLUTION'(1);

  vec_t                cnt;
  vec_t                lim;
  vec_t                snap;
  logic [CHANNELS-1:0] sticky;
  logic [CHANNELS-1:0] wrap_q;
  logic [CHANNELS-1:0] snap_ovf;
  logic                snap_vld;
  logic [CHANNELS-1:0] ovf;

  assign lim                 = bus.counter_max;
  assign bus.counter_out     = cnt;
  assign bus.snapshot        = snap;
  assign bus.overflow        = ovf;
  assign bus.wrapped         = wrap_q;
  assign bus.overflow_sticky = sticky;
  assign bus.snapshot_ovf    = snap_ovf;
  assign bus.snapshot_valid  = snap_vld;

  always_comb begin
    ovf = '0;
    for (int i = 0; i < CHANNELS; i++)
      ovf[i] = (cnt[i] == lim[i]);
  end

  // Snapshot samples pre-update state, so it
  // sees the value a same-cycle clear wipes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      sticky   <= '0;
      wrap_q   <= '0;
      snap     <= '0;
      snap_ovf <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= bus.capture;
      if (bus.capture) begin
        snap     <= cnt;
        snap_ovf <= sticky;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        wrap_q[i] <= 1'b0;
        if (bus.clear[i]) begin
          cnt[i]    <= '0;
          sticky[i] <= 1'b0;
        end else if (CLEAR_ON_CAPTURE &&
                     bus.capture) begin
          cnt[i]    <= (bus.enable[i] &&
                        lim[i] != '0) ? ONE : '0;
          sticky[i] <= 1'b0;
        end else if (bus.enable[i]) begin
          if (cnt[i] < lim[i]) begin
            cnt[i] <= cnt[i] + ONE;
          end else begin
            sticky[i] <= 1'b1;
            if (bus.mode_wrap) begin
              cnt[i]    <= '0;
              wrap_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed
// scenarios plus randomized run against a model.
module tb_counter_bank;

  localparam int CH = 4;
  localparam int RW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode_wrap;
  logic [CH-1:0]     enable;
  logic [CH-1:0]     clear;
  logic [CH*RW-1:0]  counter_max;
  logic              capture;

  int errors = 0;
  int checks = 0;

  counter_bank_if #(.CHANNELS(CH), .RESOLUTION(RW)) ifa ();
  counter_bank_if #(.CHANNELS(CH), .RESOLUTION(RW)) ifb ();

  assign ifa.mode_wrap   = mode_wrap;
  assign ifa.enable      = enable;
  assign ifa.clear       = clear;
  assign ifa.counter_max = counter_max;
  assign ifa.capture     = capture;
  assign ifb.mode_wrap   = mode_wrap;
  assign ifb.enable      = enable;
  assign ifb.clear       = clear;
  assign ifb.counter_max = counter_max;
  assign ifb.capture     = capture;

  counter_bank #(
    .CHANNELS(CH), .RESOLUTION(RW),
    .CLEAR_ON_CAPTURE(1'b0)
  ) dut0 (.clk(clk), .reset(reset), .bus(ifa.slave));

  counter_bank #(
    .CHANNELS(CH), .RESOLUTION(RW),
    .CLEAR_ON_CAPTURE(1'b1)
  ) dut1 (.clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  // reference model state, index 0 = dut0, 1 = dut1
  logic [RW-1:0] m_cnt  [2][CH];
  logic [RW-1:0] m_snap [2][CH];
  logic          m_st   [2][CH];
  logic          m_wr   [2][CH];
  logic          m_sovf [2][CH];
  logic          m_sv   [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_max(int ch, logic [RW-1:0] v);
    counter_max[ch*RW +: RW] = v;
  endtask

  function automatic logic [RW-1:0] cnt0(int ch);
    return ifa.counter_out[ch*RW +: RW];
  endfunction

  function automatic logic [RW-1:0] cnt1(int ch);
    return ifb.counter_out[ch*RW +: RW];
  endfunction

  task automatic test_reset();
    set_max(0, 3); set_max(1, 2);
    set_max(2, 10); set_max(3, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ifa.counter_out !== '0) begin
      errors++;
      $display("FAIL rst_cnt got=%h exp=0", ifa.counter_out);
    end
    checks++;
    if (ifa.overflow !== 4'b1000) begin
      errors++;
      $display("FAIL rst_ovf got=%b exp=1000", ifa.overflow);
    end
    checks++;
    if ({ifa.overflow_sticky, ifa.wrapped,
         ifa.snapshot_ovf, ifa.snapshot_valid} !== '0) begin
      errors++;
      $display("FAIL rst_flags got=%b%b%b%b exp=0",
        ifa.overflow_sticky, ifa.wrapped,
        ifa.snapshot_ovf, ifa.snapshot_valid);
    end
    checks++;
    if (ifa.snapshot !== '0) begin
      errors++;
      $display("FAIL rst_snap got=%h exp=0", ifa.snapshot);
    end
  endtask

  task automatic test_saturate();
    int exp_c [6] = '{1, 2, 3, 3, 3, 3};
    mode_wrap = 1'b0;
    set_max(0, 3);
    enable = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (cnt0(0) !== RW'(exp_c[k-1])) begin
        errors++;
        $display("FAIL sat_cnt k=%0d got=%0d exp=%0d",
          k, cnt0(0), exp_c[k-1]);
      end
      checks++;
      if (ifa.overflow[0] !== (k >= 3)) begin
        errors++;
        $display("FAIL sat_ovf k=%0d got=%b exp=%b",
          k, ifa.overflow[0], k >= 3);
      end
      checks++;
      if (ifa.overflow_sticky[0] !== (k >= 4)) begin
        errors++;
        $display("FAIL sat_sticky k=%0d got=%b exp=%b",
          k, ifa.overflow_sticky[0], k >= 4);
      end
      checks++;
      if (ifa.wrapped[0] !== 1'b0) begin
        errors++;
        $display("FAIL sat_wrap k=%0d got=1 exp=0", k);
      end
    end
    enable = '0;
    clear  = '1;
    step();
    clear  = '0;
  endtask

  task automatic test_wrap();
    int exp_c [7] = '{1, 2, 0, 1, 2, 0, 1};
    mode_wrap = 1'b1;
    set_max(1, 2);
    enable = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (cnt0(1) !== RW'(exp_c[k-1])) begin
        errors++;
        $display("FAIL wrap_cnt k=%0d got=%0d exp=%0d",
          k, cnt0(1), exp_c[k-1]);
      end
      checks++;
      if (ifa.wrapped[1] !== (k == 3 || k == 6)) begin
        errors++;
        $display("FAIL wrap_pulse k=%0d got=%b exp=%b",
          k, ifa.wrapped[1], k == 3 || k == 6);
      end
      checks++;
      if (ifa.overflow_sticky[1] !== (k >= 3)) begin
        errors++;
        $display("FAIL wrap_sticky k=%0d got=%b exp=%b",
          k, ifa.overflow_sticky[1], k >= 3);
      end
    end
    enable = '0;
    step();
    checks++;
    if ({ifa.overflow_sticky[1], ifa.wrapped[1]} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_hold got=%b%b exp=10",
        ifa.overflow_sticky[1], ifa.wrapped[1]);
    end
    clear = 4'b0010;
    step();
    clear = '0;
    checks++;
    if ({ifa.overflow_sticky[1], cnt0(1)} !== '0) begin
      errors++;
      $display("FAIL wrap_clr got=%b/%0d exp=0/0",
        ifa.overflow_sticky[1], cnt0(1));
    end
    mode_wrap = 1'b0;
  endtask

  task automatic test_capture_clear();
    set_max(2, 10);
    enable = 4'b0100;
    repeat (5) step();
    checks++;
    if (cnt0(2) !== 32'd5) begin
      errors++;
      $display("FAIL capclr_pre got=%0d exp=5", cnt0(2));
    end
    enable  = '0;
    capture = 1'b1;
    clear   = 4'b0100;
    step();
    capture = 1'b0;
    clear   = '0;
    checks++;
    if (ifa.snapshot[2*RW +: RW] !== 32'd5) begin
      errors++;
      $display("FAIL capclr_snap got=%0d exp=5",
        ifa.snapshot[2*RW +: RW]);
    end
    checks++;
    if (cnt0(2) !== 32'd0) begin
      errors++;
      $display("FAIL capclr_cnt got=%0d exp=0", cnt0(2));
    end
    checks++;
    if (ifa.snapshot_valid !== 1'b1) begin
      errors++;
      $display("FAIL capclr_sv1 got=%b exp=1", ifa.snapshot_valid);
    end
    step();
    checks++;
    if (ifa.snapshot_valid !== 1'b0) begin
      errors++;
      $display("FAIL capclr_sv0 got=%b exp=0", ifa.snapshot_valid);
    end
  endtask

  task automatic test_clear_on_capture();
    clear = '1;
    step();
    clear = '0;
    mode_wrap = 1'b0;
    set_max(0, 3);
    set_max(3, 20);
    enable = 4'b1001;
    repeat (9) step();
    checks++;
    if ({cnt1(3), ifb.overflow_sticky[0]} !== {32'd9, 1'b1}) begin
      errors++;
      $display("FAIL coc_pre got=%0d/%b exp=9/1",
        cnt1(3), ifb.overflow_sticky[0]);
    end
    capture = 1'b1;
    enable  = 4'b1000;
    step();
    capture = 1'b0;
    enable  = '0;
    checks++;
    if (ifb.snapshot[3*RW +: RW] !== 32'd9) begin
      errors++;
      $display("FAIL coc_snap got=%0d exp=9",
        ifb.snapshot[3*RW +: RW]);
    end
    checks++;
    if (cnt1(3) !== 32'd1 || cnt1(0) !== 32'd0) begin
      errors++;
      $display("FAIL coc_cnt got=%0d,%0d exp=1,0",
        cnt1(3), cnt1(0));
    end
    checks++;
    if (ifb.overflow_sticky !== 4'b0000 ||
        ifb.wrapped !== 4'b0000) begin
      errors++;
      $display("FAIL coc_flags got=%b/%b exp=0000/0000",
        ifb.overflow_sticky, ifb.wrapped);
    end
    checks++;
    if (ifb.snapshot_ovf[0] !== 1'b1 ||
        ifb.snapshot_valid !== 1'b1) begin
      errors++;
      $display("FAIL coc_sovf got=%b/%b exp=1/1",
        ifb.snapshot_ovf[0], ifb.snapshot_valid);
    end
    checks++;
    if (cnt0(3) !== 32'd10) begin
      errors++;
      $display("FAIL coc_off got=%0d exp=10", cnt0(3));
    end
  endtask

  task automatic test_max_lowered();
    clear = '1;
    step();
    clear = '0;
    mode_wrap = 1'b0;
    set_max(0, 10);
    enable = 4'b0001;
    repeat (7) step();
    set_max(0, 4);
    step();
    checks++;
    if (cnt0(0) !== 32'd7 || ifa.overflow_sticky[0] !== 1'b1 ||
        ifa.overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL low_sat got=%0d/%b/%b exp=7/1/0",
        cnt0(0), ifa.overflow_sticky[0], ifa.overflow[0]);
    end
    mode_wrap = 1'b1;
    step();
    checks++;
    if (cnt0(0) !== 32'd0 || ifa.wrapped[0] !== 1'b1) begin
      errors++;
      $display("FAIL low_wrap got=%0d/%b exp=0/1",
        cnt0(0), ifa.wrapped[0]);
    end
    enable    = '0;
    mode_wrap = 1'b0;
    step();
    checks++;
    if (ifa.wrapped[0] !== 1'b0) begin
      errors++;
      $display("FAIL low_pulse got=%b exp=0", ifa.wrapped[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < CH; i++) set_max(i, 100);
    enable = '1;
    repeat (3) step();
    capture = 1'b1;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    capture = 1'b0;
    enable  = '0;
    checks++;
    if ({ifa.counter_out, ifb.counter_out,
         ifa.snapshot, ifb.snapshot} !== '0) begin
      errors++;
      $display("FAIL rmid_vals got=%h/%h exp=0",
        ifa.counter_out, ifb.counter_out);
    end
    checks++;
    if ({ifa.overflow_sticky, ifa.wrapped, ifa.snapshot_ovf,
         ifa.snapshot_valid, ifb.snapshot_valid} !== '0) begin
      errors++;
      $display("FAIL rmid_flags got=%b%b%b%b%b exp=0",
        ifa.overflow_sticky, ifa.wrapped, ifa.snapshot_ovf,
        ifa.snapshot_valid, ifb.snapshot_valid);
    end
    step();
    checks++;
    if ({ifa.snapshot_valid, ifb.snapshot_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_sv got=%b%b exp=00",
        ifa.snapshot_valid, ifb.snapshot_valid);
    end
  endtask

  task automatic model_step();
    logic [RW-1:0] mx;
    logic [RW-1:0] c;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_sv[d] = 1'b0;
        for (int i = 0; i < CH; i++) begin
          m_cnt[d][i] = '0; m_snap[d][i] = '0;
          m_st[d][i] = 0; m_wr[d][i] = 0; m_sovf[d][i] = 0;
        end
      end else begin
        m_sv[d] = capture;
        for (int i = 0; i < CH; i++) begin
          mx = counter_max[i*RW +: RW];
          c  = m_cnt[d][i];
          if (capture) begin
            m_snap[d][i] = c;
            m_sovf[d][i] = m_st[d][i];
          end
          m_wr[d][i] = 0;
          if (clear[i]) begin
            m_cnt[d][i] = 0; m_st[d][i] = 0;
          end else if (d == 1 && capture) begin
            m_cnt[d][i] = (enable[i] && mx != 0) ? 1 : 0;
            m_st[d][i]  = 0;
          end else if (enable[i]) begin
            if (c < mx) m_cnt[d][i] = c + 1;
            else begin
              m_st[d][i] = 1;
              if (mode_wrap) begin
                m_cnt[d][i] = 0; m_wr[d][i] = 1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [CH*RW-1:0] e_cnt, e_snap, a_cnt, a_snap;
    logic [CH-1:0] e_ovf, e_wr, e_st, e_so;
    logic [CH-1:0] a_ovf, a_wr, a_st, a_so;
    logic a_sv;
    enable = '0; clear = '0; capture = 1'b0;
    reset = 1'b1;
    model_step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0 || n == 0)
        for (int i = 0; i < CH; i++)
          set_max(i, RW'($urandom_range(6)));
      enable  = CH'($urandom);
      for (int i = 0; i < CH; i++)
        clear[i] = ($urandom_range(9) == 0);
      capture = ($urandom_range(4) == 0);
      if ($urandom_range(7) == 0) mode_wrap = ~mode_wrap;
      reset   = ($urandom_range(99) == 0);
      model_step();
      step();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < CH; i++) begin
          e_cnt[i*RW +: RW]  = m_cnt[d][i];
          e_snap[i*RW +: RW] = m_snap[d][i];
          e_ovf[i] = (m_cnt[d][i] == counter_max[i*RW +: RW]);
          e_wr[i]  = m_wr[d][i];
          e_st[i]  = m_st[d][i];
          e_so[i]  = m_sovf[d][i];
        end
        a_cnt  = d ? ifb.counter_out     : ifa.counter_out;
        a_snap = d ? ifb.snapshot        : ifa.snapshot;
        a_ovf  = d ? ifb.overflow        : ifa.overflow;
        a_wr   = d ? ifb.wrapped         : ifa.wrapped;
        a_st   = d ? ifb.overflow_sticky : ifa.overflow_sticky;
        a_so   = d ? ifb.snapshot_ovf    : ifa.snapshot_ovf;
        a_sv   = d ? ifb.snapshot_valid  : ifa.snapshot_valid;
        checks++;
        if (a_cnt !== e_cnt) begin
          errors++;
          $display("FAIL rnd_cnt n=%0d d=%0d got=%h exp=%h",
            n, d, a_cnt, e_cnt);
        end
        checks++;
        if (a_snap !== e_snap) begin
          errors++;
          $display("FAIL rnd_snap n=%0d d=%0d got=%h exp=%h",
            n, d, a_snap, e_snap);
        end
        checks++;
        if ({a_ovf, a_wr, a_st, a_so} !==
            {e_ovf, e_wr, e_st, e_so}) begin
          errors++;
          $display("FAIL rnd_flags n=%0d d=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b",
            n, d, a_ovf, a_wr, a_st, a_so,
            e_ovf, e_wr, e_st, e_so);
        end
        checks++;
        if (a_sv !== m_sv[d]) begin
          errors++;
          $display("FAIL rnd_sv n=%0d d=%0d got=%b exp=%b",
            n, d, a_sv, m_sv[d]);
        end
      end
    end
    reset = 1'b0; enable = '0; clear = '0; capture = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    mode_wrap   = 1'b0;
    enable      = '0;
    clear       = '0;
    capture     = 1'b0;
    counter_max = '0;
    step();
    test_reset();
    test_saturate();
    test_wrap();
    test_capture_clear();
    test_clear_on_capture();
    test_max_lowered();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
